// File: rtl/prot_pkg.sv
// Shared definitions for the fault protection block: register map, FSM states, reset defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package prot_pkg;

   // Register word offsets (byte address >> 2)
   localparam logic [5:0] REG_STATUS    = 6'h00;
   localparam logic [5:0] REG_ENABLE    = 6'h01;
   localparam logic [5:0] REG_CLEAR     = 6'h02;
   localparam logic [5:0] REG_WDOG_VAL  = 6'h03;
   localparam logic [5:0] REG_WDOG_KICK = 6'h04;
   localparam logic [5:0] REG_LATCH     = 6'h05;
   localparam logic [5:0] REG_POLARITY  = 6'h06;
   localparam logic [5:0] REG_FILT_LEN  = 6'h07;
   localparam logic [5:0] REG_STATE     = 6'h08;
   localparam logic [5:0] REG_IRQ_MASK  = 6'h09;
   localparam logic [5:0] REG_HOLDOFF   = 6'h0A;
   localparam logic [5:0] REG_FF_CHAN   = 6'h0B;
   localparam logic [5:0] REG_FF_TIME   = 6'h0C;

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_TRIPPED = 2'd1,
      ST_HOLDOFF = 2'd2
   } prot_state_t;

   // Reset defaults, sliced to the live width by the user
   localparam logic [31:0] ENABLE_RST   = 32'hFFFF_FFFF;
   localparam logic [31:0] FILT_LEN_RST = 32'd4;
   localparam logic [31:0] IRQ_MASK_RST = 32'd0;

   // The watchdog sits just above the external channels
   function automatic int wdog_ch(input int n_ch);
      return n_ch;
   endfunction

endpackage

// File: rtl/prot_filter.sv
// One fault channel: 2-flop synchroniser, polarity inversion, debounce filter.
// Latency: filt_len+3 clk edges from pin change to filt output.
// Backpressure: none; free-running sampler.
module prot_filter #(
   parameter int FILT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pin,
   input  logic              pol,
   input  logic [FILT_W-1:0] filt_len,
   output logic              filt
);

   logic              sync1;
   logic              sync2;
   logic              samp;
   logic [FILT_W-1:0] cnt;

   assign samp = sync2 ^ pol;

   // Synchronise the pin, then flip the output once it has disagreed for filt_len+1 samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         filt  <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (samp != filt) begin
            if (cnt >= filt_len) begin
               filt <= samp;
               cnt  <= '0;
            end else begin
               cnt <= cnt + FILT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/protection_mc.sv
// Fault protection peripheral: filtered fault pins + watchdog, trip FSM, PWM kill, irq; optional PROT_FIRST_FAULT_EN capture.
// Latency: pin to STATUS FILT_LEN+3 edges, pwm_disable same cycle as STATUS; bus ack one cycle after strobe.
// Backpressure: none; every strobe is acked next cycle, fault inputs are sampled every cycle.
module protection_mc
   import prot_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int N_CH         = 8,
   parameter int FILT_W       = 8,
   parameter int HOLD_W       = 16,
   parameter int HOLDOFF_RST  = 16,
   parameter int WDOG_DEFAULT = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic                  wb_we,
   input  logic [3:0]            wb_sel,
   input  logic                  wb_stb,
   output logic                  wb_ack,
   input  logic [N_CH-1:0]       fault_in,
   output logic                  pwm_disable,
   output logic                  irq
);

   localparam int NW = N_CH + 1;
   localparam int WD = wdog_ch(N_CH);

   logic [N_CH-1:0]   filt;
   logic [NW-1:0]     raw;
   logic [NW-1:0]     status;
   logic [NW-1:0]     latch;
   logic [NW-1:0]     enable;
   logic [NW-1:0]     irq_mask;
   logic [NW-1:0]     clr;
   logic [N_CH-1:0]   polarity;
   logic [FILT_W-1:0] filt_len;
   logic [31:0]       wdog_val;
   logic [31:0]       wd_cnt;
   logic              wd_exp;
   logic [HOLD_W-1:0] holdoff;
   logic [HOLD_W-1:0] hold_cnt;
   prot_state_t       state;
   logic [7:0]        trip_cnt;
   logic              acc;
   logic              wr;
   logic              kick;
   logic [5:0]        word;
   logic [31:0]       rdat;
   logic              unused_bits;

   // Byte lanes and low address bits carry no meaning: full-word registers only
   assign unused_bits = ^{wb_sel, wb_addr, wb_dat_i};

   assign acc  = wb_stb & ~wb_ack;
   assign wr   = acc & wb_we;
   assign word = wb_addr[7:2];
   assign kick = wr && (word == REG_WDOG_KICK);
   assign clr  = (wr && (word == REG_CLEAR)) ? wb_dat_i[NW-1:0] : '0;

   for (genvar g = 0; g < N_CH; g++) begin : g_filt
      prot_filter #(.FILT_W(FILT_W)) u_filt (
         .clk      (clk),
         .rst_n    (rst_n),
         .pin      (fault_in[g]),
         .pol      (polarity[g]),
         .filt_len (filt_len),
         .filt     (filt[g])
      );
   end

   assign raw[N_CH-1:0] = filt;
   assign raw[WD]       = wd_exp;
   assign status        = raw & enable;
   assign pwm_disable   = (state != ST_ARMED) | (|status);

   // Bus handshake, register writes and registered read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_ack   <= 1'b0;
         wb_dat_o <= '0;
         enable   <= ENABLE_RST[NW-1:0];
         polarity <= '0;
         filt_len <= FILT_LEN_RST[FILT_W-1:0];
         irq_mask <= IRQ_MASK_RST[NW-1:0];
         wdog_val <= 32'(WDOG_DEFAULT);
         holdoff  <= HOLD_W'(HOLDOFF_RST);
      end else begin
         wb_ack <= wb_stb & ~wb_ack;
         if (acc && !wb_we) wb_dat_o <= rdat;
         if (wr) begin
            case (word)
               REG_ENABLE:   enable   <= wb_dat_i[NW-1:0];
               REG_WDOG_VAL: wdog_val <= wb_dat_i;
               REG_POLARITY: polarity <= wb_dat_i[N_CH-1:0];
               REG_FILT_LEN: filt_len <= wb_dat_i[FILT_W-1:0];
               REG_IRQ_MASK: irq_mask <= wb_dat_i[NW-1:0];
               REG_HOLDOFF:  holdoff  <= wb_dat_i[HOLD_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // Sticky fault record (new faults beat a simultaneous clear) and masked level irq
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         latch <= '0;
         irq   <= 1'b0;
      end else begin
         latch <= (latch & ~clr) | status;
         irq   <= |(latch & irq_mask);
      end
   end

   // Watchdog: count while enabled, hold expiry until kicked; a kick always wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         wd_exp <= 1'b0;
      end else if (kick) begin
         wd_cnt <= '0;
         wd_exp <= 1'b0;
      end else if (wdog_val != '0) begin
         if (wd_cnt >= wdog_val) wd_exp <= 1'b1;
         else                    wd_cnt <= wd_cnt + 32'd1;
      end
   end

   // Trip sequencer; reset lands in HOLDOFF so a reset mid-trip still waits out the hold-off
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_HOLDOFF;
         hold_cnt <= HOLD_W'(HOLDOFF_RST);
         trip_cnt <= '0;
      end else begin
         case (state)
            ST_ARMED: begin
               if (|status) begin
                  state <= ST_TRIPPED;
                  if (trip_cnt != 8'hFF) trip_cnt <= trip_cnt + 8'd1;
               end
            end
            ST_TRIPPED: begin
               if ((latch == '0) && (status == '0)) begin
                  state    <= ST_HOLDOFF;
                  hold_cnt <= holdoff;
               end
            end
            ST_HOLDOFF: begin
               if (|status)                state    <= ST_TRIPPED;
               else if (hold_cnt == '0)    state    <= ST_ARMED;
               else                        hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            default: state <= ST_HOLDOFF;
         endcase
      end
   end

`ifdef PROT_FIRST_FAULT_EN
   logic [31:0] ts;
   logic [31:0] ff_time;
   logic [4:0]  ff_chan;
   logic [4:0]  ff_low;

   // Lowest-numbered active channel
   always_comb begin
      ff_low = '0;
      for (int i = NW - 1; i >= 0; i--) begin
         if (status[i]) ff_low = 5'(i);
      end
   end

   // Free-running timestamp; first-fault record frozen until the next trip from ARMED
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts      <= '0;
         ff_time <= '0;
         ff_chan <= '0;
      end else begin
         ts <= ts + 32'd1;
         if ((state == ST_ARMED) && (|status)) begin
            ff_time <= ts;
            ff_chan <= ff_low;
         end
      end
   end
`endif

   // Read mux; unmapped and write-only offsets return zero
   always_comb begin
      rdat = '0;
      case (word)
         REG_STATUS:   rdat[NW-1:0]     = status;
         REG_ENABLE:   rdat[NW-1:0]     = enable;
         REG_WDOG_VAL: rdat             = wdog_val;
         REG_LATCH:    rdat[NW-1:0]     = latch;
         REG_POLARITY: rdat[N_CH-1:0]   = polarity;
         REG_FILT_LEN: rdat[FILT_W-1:0] = filt_len;
         REG_STATE: begin
            rdat[1:0]  = state;
            rdat[15:8] = trip_cnt;
         end
         REG_IRQ_MASK: rdat[NW-1:0]     = irq_mask;
         REG_HOLDOFF:  rdat[HOLD_W-1:0] = holdoff;
`ifdef PROT_FIRST_FAULT_EN
         REG_FF_CHAN:  rdat[4:0]        = ff_chan;
         REG_FF_TIME:  rdat             = ff_time;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_protection_mc.sv
// Directed bench for protection_mc: reset, filter, latch/clear, FSM, polarity, watchdog, first-fault capture.
// Latency: n/a.
// Backpressure: n/a.
module tb_protection_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  wb_addr = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'hF;
   logic        wb_stb = 1'b0;
   logic        wb_ack;
   logic [7:0]  fault_in = '0;
   logic        pwm_disable;
   logic        irq;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   logic [31:0] rd;
   logic [31:0] exp_time;
   logic        seen;

   protection_mc #(
      .ADDR_WIDTH(8), .N_CH(8), .FILT_W(8), .HOLD_W(16),
      .HOLDOFF_RST(16), .WDOG_DEFAULT(50_000_000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_addr     (wb_addr),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_we       (wb_we),
      .wb_sel      (wb_sel),
      .wb_stb      (wb_stb),
      .wb_ack      (wb_ack),
      .fault_in    (fault_in),
      .pwm_disable (pwm_disable),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Cycle count since reset release, same origin as the timestamp counter
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Each access takes two edges: the acked edge and one idle edge
   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      wb_addr = a; wb_dat_i = d; wb_we = 1'b1; wb_stb = 1'b1;
      @(posedge clk); #1;
      check("wr_ack", {31'b0, wb_ack}, 32'd1);
      wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
      @(posedge clk); #1;
      check("rd_ack", {31'b0, wb_ack}, 32'd1);
      d = wb_dat_o;
      wb_stb = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      // ---- 1: reset and hold-off release ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", {31'b0, pwm_disable}, 32'd1);
      check("rst_ack", {31'b0, wb_ack}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      bus_rd(8'h20, rd); check("rst_state", rd, 32'h0000_0002);
      bus_rd(8'h04, rd); check("rst_enable", rd, 32'h0000_01FF);
      repeat (12) @(posedge clk);
      #1;
      check("holdoff_edge16", {31'b0, pwm_disable}, 32'd1);
      @(posedge clk); #1;
      check("armed_edge17", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h0C, rd); check("rst_wdog_val", rd, 32'd50_000_000);
      bus_rd(8'h1C, rd); check("rst_filt_len", rd, 32'd4);
      bus_rd(8'h28, rd); check("rst_holdoff", rd, 32'd16);
      bus_rd(8'h14, rd); check("rst_latch", rd, 32'd0);
      bus_rd(8'h3C, rd); check("unmapped_rd", rd, 32'd0);
      bus_rd(8'h10, rd); check("kick_rd", rd, 32'd0);

      // ---- 2: debounce ----
      fault_in[2] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      fault_in[2] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("short_pulse_pwm", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h00, rd); check("short_pulse_status", rd, 32'd0);

      fault_in[2] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("filt_edge6", {31'b0, pwm_disable}, 32'd0);
      @(posedge clk); #1;
      check("filt_edge7", {31'b0, pwm_disable}, 32'd1);
      bus_rd(8'h00, rd); check("trip_status", rd, 32'h004);
      bus_rd(8'h14, rd); check("trip_latch", rd, 32'h004);
      bus_rd(8'h20, rd); check("trip_state", rd, 32'h0101);
      check("irq_masked", {31'b0, irq}, 32'd0);
      bus_wr(8'h24, 32'h004);
      check("irq_unmasked", {31'b0, irq}, 32'd1);

      // ---- 3: clear semantics and hold-off re-trip ----
      bus_wr(8'h28, 32'd100);
      bus_rd(8'h28, rd); check("holdoff_rb", rd, 32'd100);
      bus_wr(8'h08, 32'h004);
      bus_rd(8'h14, rd); check("clr_while_active", rd, 32'h004);
      fault_in[2] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus_rd(8'h00, rd); check("status_dropped", rd, 32'd0);
      bus_wr(8'h08, 32'h004);
      check("irq_after_clr", {31'b0, irq}, 32'd0);
      bus_rd(8'h20, rd); check("state_holdoff", rd, 32'h0102);
      fault_in[2] = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      bus_rd(8'h20, rd); check("retrip_no_count", rd, 32'h0101);
      bus_wr(8'h28, 32'd0);
      fault_in[2] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus_wr(8'h08, 32'h004);
      check("holdoff0_in_ho", {31'b0, pwm_disable}, 32'd1);
      @(posedge clk); #1;
      check("holdoff0_armed", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h20, rd); check("state_armed", rd, 32'h0100);

      // ---- 4: polarity ----
      fault_in[0] = 1'b1;
      bus_wr(8'h18, 32'h001);
      bus_rd(8'h18, rd); check("polarity_rb", rd, 32'h001);
      repeat (10) @(posedge clk);
      #1;
      check("pol_high_ok", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h00, rd); check("pol_high_status", rd, 32'd0);
      fault_in[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("pol_low_trip", {31'b0, pwm_disable}, 32'd1);
      @(posedge clk); #1;
      bus_rd(8'h14, rd); check("pol_latch", rd, 32'h001);
      bus_rd(8'h20, rd); check("pol_state", rd, 32'h0201);
      fault_in[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus_wr(8'h08, 32'h1FF);
      @(posedge clk); #1;
      check("pol_rearm", {31'b0, pwm_disable}, 32'd0);

      // ---- 5: watchdog ----
      bus_wr(8'h0C, 32'd0);
      bus_wr(8'h10, 32'd0);
      bus_wr(8'h0C, 32'd100);
      repeat (99) @(posedge clk);
      #1;
      check("wd_before", {31'b0, pwm_disable}, 32'd0);
      @(posedge clk); #1;
      check("wd_expire", {31'b0, pwm_disable}, 32'd1);
      @(posedge clk); #1;
      bus_rd(8'h14, rd); check("wd_latch", rd, 32'h100);
      bus_wr(8'h10, 32'd0);
      bus_wr(8'h08, 32'h100);
      @(posedge clk); #1;
      check("wd_rearm", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h20, rd); check("wd_state", rd, 32'h0300);
      for (int k = 0; k < 4; k++) begin
         repeat (86) @(posedge clk);
         #1;
         bus_wr(8'h10, 32'd0);
      end
      check("wd_kicked_pwm", {31'b0, pwm_disable}, 32'd0);
      bus_rd(8'h14, rd); check("wd_kicked_latch", rd, 32'd0);
      bus_wr(8'h0C, 32'd0);
      repeat (150) @(posedge clk);
      #1;
      bus_rd(8'h14, rd); check("wd_off_latch", rd, 32'd0);

      // ---- 6: first-fault capture ----
`ifdef PROT_FIRST_FAULT_EN
      fault_in[3] = 1'b1;
      fault_in[5] = 1'b1;
      seen = 1'b0;
      exp_time = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (pwm_disable && !seen) begin
            seen = 1'b1;
            exp_time = cyc;
         end
      end
      check("ff_trip_seen", {31'b0, seen}, 32'd1);
      fault_in[1] = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      bus_rd(8'h00, rd); check("ff_status", rd, 32'h02A);
      bus_rd(8'h2C, rd); check("ff_chan", rd, 32'd3);
      bus_rd(8'h30, rd); check("ff_time", rd, exp_time);
`else
      bus_rd(8'h2C, rd); check("ff_chan_absent", rd, 32'd0);
      bus_rd(8'h30, rd); check("ff_time_absent", rd, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
